// File: rtl/vram_responder.sv
// vram_responder: time-shared 2 KB video RAM serving renderer fetches and a CPU req/ack port.
// Optional VRAM_CLEAR_ON_RESET_EN: zero-fill the RAM after reset while holding busy.
module vram_responder #(
    parameter logic [15:0] VRAM_BASE  = 16'h4000,
    parameter int          VRAM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] tile_RAM_addr,
    input  logic [15:0] palette_RAM_addr,
    output logic [7:0]  tile_ROM_addr,
    output logic [5:0]  palette_ROM_addr,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        busy
);
    localparam int AW = $clog2(VRAM_DEPTH);

    function automatic logic in_win(input logic [15:0] a);
        return (32'(a) >= 32'(VRAM_BASE)) && (32'(a) < 32'(VRAM_BASE) + VRAM_DEPTH);
    endfunction

    function automatic logic [AW-1:0] to_idx(input logic [15:0] a);
        return AW'(a - VRAM_BASE);
    endfunction

    logic [1:0]    slot;
    logic          run;
    logic          clearing;
    logic [AW-1:0] clr_idx;
    logic          tile_ok_q;
    logic          pal_ok_q;
    logic [AW-1:0] pal_idx_q;
    logic [7:0]    tile_byte_q;
    logic          cpu_pend;
    logic          cpu_pend_rd;
    logic          cpu_pend_ok;
    logic [7:0]    cpu_rdata_q;
    logic [7:0]    mem [VRAM_DEPTH];
    logic [7:0]    ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic          cpu_ok;

    assign cpu_ok = in_win(cpu_addr);

`ifdef VRAM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {INIT, CLEAR, RUN} state_t;
    state_t state, state_nx;

    // clear state register and fill index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= (state == CLEAR) ? clr_idx + AW'(1) : '0;
        end
    end

    // sequence: one idle cycle after reset, then fill every index, then run
    always_comb begin
        state_nx = (state == INIT)  ? CLEAR :
                   (state == CLEAR) ? ((clr_idx == AW'(VRAM_DEPTH - 1)) ? RUN : CLEAR) : RUN;
    end

    // busy covers exactly the fill cycles; slots only run afterwards
    always_comb begin
        busy     = (state == CLEAR);
        clearing = (state == CLEAR);
        run      = (state == RUN);
    end
`else
    assign busy     = 1'b0;
    assign clearing = 1'b0;
    assign run      = 1'b1;
    assign clr_idx  = '0;
`endif

    // RAM port owner per slot: tile, palette, CPU, idle; the fill overrides everything
    always_comb begin
        ram_addr  = clearing ? clr_idx :
                    (slot == 2'd0) ? to_idx(tile_RAM_addr) :
                    (slot == 2'd1) ? pal_idx_q : to_idx(cpu_addr);
        ram_en    = run && ((slot == 2'd0) ? in_win(tile_RAM_addr) :
                            (slot == 2'd1) ? pal_ok_q :
                            (slot == 2'd2) ? (cpu_req && cpu_ok) : 1'b0);
        ram_we    = clearing || (run && slot == 2'd2 && cpu_req && cpu_we && cpu_ok);
        ram_wdata = clearing ? 8'h00 : cpu_wdata;
    end

    // single-port RAM with registered read; read returns the pre-write contents
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en) ram_q <= mem[ram_addr];
    end

    // slot counter, renderer latches, video output registers and CPU op tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot             <= 2'd0;
            tile_ok_q        <= 1'b0;
            pal_ok_q         <= 1'b0;
            pal_idx_q        <= '0;
            tile_byte_q      <= 8'h00;
            tile_ROM_addr    <= 8'h00;
            palette_ROM_addr <= 6'h00;
            cpu_pend         <= 1'b0;
            cpu_pend_rd      <= 1'b0;
            cpu_pend_ok      <= 1'b0;
            cpu_rdata_q      <= 8'h00;
        end else if (run) begin
            slot        <= slot + 2'd1;
            cpu_rdata_q <= cpu_rdata;
            case (slot)
                2'd0: begin
                    tile_ok_q <= in_win(tile_RAM_addr);
                    pal_ok_q  <= in_win(palette_RAM_addr);
                    pal_idx_q <= to_idx(palette_RAM_addr);
                end
                2'd1: tile_byte_q <= tile_ok_q ? ram_q : 8'h00;
                2'd2: begin
                    tile_ROM_addr    <= tile_byte_q;
                    palette_ROM_addr <= pal_ok_q ? ram_q[5:0] : 6'h00;
                    cpu_pend         <= cpu_req;
                    cpu_pend_rd      <= ~cpu_we;
                    cpu_pend_ok      <= cpu_ok;
                end
                default: cpu_pend <= 1'b0;
            endcase
        end
    end

    // slot 3 pulses; read data comes straight off the RAM and is then held
    always_comb begin
        vid_valid = run && (slot == 2'd3);
        cpu_ack   = vid_valid && cpu_pend;
        cpu_rdata = (cpu_ack && cpu_pend_rd) ? (cpu_pend_ok ? ram_q : 8'hFF) : cpu_rdata_q;
    end
endmodule

// File: tb/tb_vram_responder.sv
// tb_vram_responder: randomized bench with a byte-array model of the video RAM window.
module tb_vram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tile_RAM_addr = '0;
    logic [15:0] palette_RAM_addr = '0;
    logic [7:0]  tile_ROM_addr;
    logic [5:0]  palette_ROM_addr;
    logic        vid_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vram_responder dut (
        .clk(clk), .rst(rst),
        .tile_RAM_addr(tile_RAM_addr), .palette_RAM_addr(palette_RAM_addr),
        .tile_ROM_addr(tile_ROM_addr), .palette_ROM_addr(palette_ROM_addr),
        .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .busy(busy)
    );

`ifdef VRAM_CLEAR_ON_RESET_EN
    localparam logic [7:0] AFTER_RST_4025 = 8'h00;
`else
    localparam logic [7:0] AFTER_RST_4025 = 8'h5A;
`endif

    // model: RAM bytes with known flags, round phase, and expected outputs
    logic [7:0]  mm [2048];
    bit          kn [2048];
    int          mst;
    int          ph;
    int          cnt;
    bit          pend;
    logic [7:0]  e_tile, e_rd, l_tile;
    logic [5:0]  e_pal, l_pal;
    bit          e_tile_kn, e_pal_kn, e_rd_kn, l_tile_kn, l_pal_kn;
    bit          jitter = 1'b0;
    int          busy_cnt = 0;
    logic [15:0] pool [12] = '{16'h0000, 16'h4000, 16'h4025, 16'h4100, 16'h43FF, 16'h4400,
                               16'h4425, 16'h47FF, 16'h4800, 16'h3FFF, 16'h5000, 16'hFFFF};

    function automatic bit in_win(input logic [15:0] a);
        return a >= 16'h4000 && a <= 16'h47FF;
    endfunction

    function automatic int ix(input logic [15:0] a);
        return int'(a) - 'h4000;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic look(input logic [15:0] a, output logic [7:0] v, output bit k);
        if (!in_win(a)) begin
            v = 8'h00;
            k = 1'b1;
        end else begin
            v = mm[ix(a)];
            k = kn[ix(a)];
        end
    endtask

    task automatic model_edge();
        logic [7:0] v;
        if (rst) begin
`ifdef VRAM_CLEAR_ON_RESET_EN
            mst = 0;
`else
            mst = 2;
`endif
            ph = 0; pend = 0; cnt = 0;
            e_tile = 0; e_pal = 0; e_rd = 0;
            e_tile_kn = 1; e_pal_kn = 1; e_rd_kn = 1;
        end else if (mst == 0) begin
            mst = 1;
        end else if (mst == 1) begin
            mm[cnt] = 8'h00;
            kn[cnt] = 1'b1;
            cnt++;
            if (cnt == 2048) mst = 2;
        end else begin
            if (ph == 0) begin
                look(tile_RAM_addr, l_tile, l_tile_kn);
                look(palette_RAM_addr, v, l_pal_kn);
                l_pal = v[5:0];
            end else if (ph == 2) begin
                e_tile = l_tile; e_tile_kn = l_tile_kn;
                e_pal = l_pal; e_pal_kn = l_pal_kn;
                pend = cpu_req;
                if (cpu_req && cpu_we && in_win(cpu_addr)) begin
                    mm[ix(cpu_addr)] = cpu_wdata;
                    kn[ix(cpu_addr)] = 1'b1;
                end else if (cpu_req && !cpu_we) begin
                    if (in_win(cpu_addr)) look(cpu_addr, e_rd, e_rd_kn);
                    else begin
                        e_rd = 8'hFF;
                        e_rd_kn = 1'b1;
                    end
                end
            end else if (ph == 3) begin
                pend = 0;
            end
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic check_outputs();
        bit ack_e;
        ack_e = (mst == 2 && ph == 3 && pend);
        chk("vid_valid", vid_valid, (mst == 2 && ph == 3));
        chk("cpu_ack", cpu_ack, ack_e);
        chk("busy", busy, (mst == 1));
        if (e_tile_kn) chk("tile_ROM_addr", tile_ROM_addr, e_tile);
        if (e_pal_kn) chk("palette_ROM_addr", palette_ROM_addr, e_pal);
        if (ack_e && e_rd_kn) chk("cpu_rdata", cpu_rdata, e_rd);
        if (busy) busy_cnt++;
    endtask

    task automatic tick();
        if (jitter) begin
            tile_RAM_addr = pool[$urandom_range(11)];
            palette_RAM_addr = pool[$urandom_range(11)];
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 2200 && mst != 2; i++) tick();
    endtask

    task automatic cpu_op(input bit we, input logic [15:0] a, input logic [7:0] d, output logic [7:0] rd);
        bit got;
        got = 1'b0;
        rd = 8'h00;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        wait_run();
        for (int n = 1; n <= 8 && !got; n++) begin
            tick();
            if (cpu_ack) begin
                got = 1'b1;
                rd = cpu_rdata;
                total++;
                if (n > 4) begin
                    bad++;
                    $display("FAIL ack_delay: got %0d clks expected <=4", n);
                end
            end
        end
        cpu_req = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: no cpu_ack for addr %h", a);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int seen;
        tick();
        chk("rst_tile", tile_ROM_addr, 8'h00);
        chk("rst_pal", palette_ROM_addr, 6'h00);
        chk("rst_vid", vid_valid, 1'b0);
        chk("rst_ack", cpu_ack, 1'b0);
        chk("rst_rdata", cpu_rdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (12) tick();
        wait_run();
        repeat (8) tick();
        foreach (pool[i])
            if (in_win(pool[i])) cpu_op(1'b1, pool[i], (pool[i] == 16'h4000) ? 8'h3C : 8'($urandom), rd);
        cpu_op(1'b1, 16'h4025, 8'h5A, rd);
        cpu_op(1'b1, 16'h4425, 8'h3F, rd);
        tile_RAM_addr = 16'h4025;
        palette_RAM_addr = 16'h4425;
        seen = 0;
        for (int i = 0; i < 12 && seen < 2; i++) begin
            tick();
            if (vid_valid) seen++;
        end
        chk("vid_pulses", seen, 2);
        chk("vid_tile_5A", tile_ROM_addr, 8'h5A);
        chk("vid_pal_3F", palette_ROM_addr, 6'h3F);
        cpu_op(1'b1, 16'h4100, 8'hA7, rd);
        cpu_op(1'b0, 16'h4100, 8'h00, rd);
        chk("rd_4100", rd, 8'hA7);
        cpu_op(1'b1, 16'h5000, 8'h11, rd);
        cpu_op(1'b0, 16'h5000, 8'h00, rd);
        chk("rd_5000", rd, 8'hFF);
        cpu_op(1'b0, 16'h4000, 8'h00, rd);
        chk("rd_4000", rd, 8'h3C);
        for (int i = 0; i < 4 && ph != 1; i++) tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4025;
        rst = 1'b1;
        tick();
        chk("midrst_tile", tile_ROM_addr, 8'h00);
        chk("midrst_pal", palette_ROM_addr, 6'h00);
        chk("midrst_ack", cpu_ack, 1'b0);
        rst = 1'b0;
        cpu_op(1'b0, 16'h4025, 8'h00, rd);
        chk("midrst_rd", rd, AFTER_RST_4025);
        jitter = 1'b1;
        repeat (300) begin
            if ($urandom_range(3) == 0) repeat ($urandom_range(1, 6)) tick();
            else cpu_op(1'($urandom_range(1)), pool[$urandom_range(11)], 8'($urandom), rd);
        end
        jitter = 1'b0;
`ifdef VRAM_CLEAR_ON_RESET_EN
        cpu_op(1'b1, 16'h4010, 8'h77, rd);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy_cnt = 0;
        wait_run();
        tick();
        chk("busy_len", busy_cnt, 2048);
        cpu_op(1'b0, 16'h4010, 8'h00, rd);
        chk("clear_4010", rd, 8'h00);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_responder.md
Name: vram_responder

Overview:
- Owns the 2 KB video RAM window: tile codes at 0x4000-0x43FF, palette/colour bytes at 0x4400-0x47FF.
- Answers the tile renderer's broadcast tile and palette RAM addresses with the tile code and palette index it consumes.
- Serves a CPU read/write port through a req/ack handshake.
- One single-port synchronous-read RAM is time-shared by a fixed 4-slot schedule, so video fetch latency is deterministic.

Parameters:
- VRAM_BASE, 16'h4000, first byte address of the window.
- VRAM_DEPTH, 2048, bytes in the window; the index is addr minus VRAM_BASE, 11 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tile_RAM_addr  in  16  tile byte address from renderer; 0x0000 during blank
- palette_RAM_addr  in  16  palette byte address from renderer; 0x0000 during blank
- tile_ROM_addr  out  8  fetched tile code
- palette_ROM_addr  out  6  fetched palette byte, bits [5:0]
- vid_valid  out  1  one-cycle pulse: tile/palette outputs just updated
- cpu_req  in  1  CPU access request, held until ack
- cpu_we  in  1  1 = write, 0 = read; stable while req
- cpu_addr  in  16  CPU byte address; stable while req
- cpu_wdata  in  8  write data; stable while req
- cpu_rdata  out  8  read data, valid while cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- busy  out  1  high while the RAM is not serving; see Optional Feature

Behaviour:
- Reset (async) values:
  - slot = 0
  - tile_ROM_addr = 0, palette_ROM_addr = 0
  - vid_valid = 0, cpu_ack = 0, cpu_rdata = 0
  - busy = 0, plus all internal latches = 0
  - RAM contents are not reset.
- slot is a 2-bit counter that increments every clk and wraps 3 -> 0.
- Synchronous RAM: an address presented in cycle N gives data in cycle N+1.
- Slot 0:
  - Latch tile_RAM_addr and palette_RAM_addr together, so both are coherent from the same renderer cycle.
  - Drive the RAM with the tile index.
- Slot 1:
  - Capture the tile data into tile_byte_q.
  - Drive the RAM with the palette index.
- Slot 2:
  - Capture the palette data.
  - At the end of the slot, load tile_ROM_addr <= tile_byte_q and palette_ROM_addr <= data[5:0].
  - If cpu_req is high, drive the RAM with the CPU index; if cpu_we is also set, write cpu_wdata at this edge.
- Slot 3:
  - vid_valid = 1 for this cycle only.
  - If a CPU op was issued in slot 2: cpu_ack = 1 and cpu_rdata = RAM data (reads) or the previous value (writes).
  - RAM idle.
- Latency:
  - Renderer addresses sampled in slot 0 appear on the outputs in slot 3.
  - Video update period is 4 clks; outputs hold between updates.
- Out-of-window video address (includes blank 0x0000): the fetched byte is forced to 0x00, with no RAM access.
- Out-of-window CPU address:
  - Write is ignored; read returns 0xFF.
  - cpu_ack is still given on the normal slot timing.
- CPU requests are sampled only in slot 2. The worst-case req-to-ack time is 4 clks. At most one CPU op per 4-clk round.
- After ack, the requester must drop cpu_req or present a new op. A req still high in the next slot 2 is treated as a new op.
- CPU write then video read of the same address:
  - A write in slot 2 is seen by the slot 0/1 fetch of the next round.
  - No same-round forwarding.
- Reset mid-op: the pending CPU op is lost and no ack is issued. The CPU must hold req; it is re-served in the first slot 2 after release.

Optional Feature:
- Macro: VRAM_CLEAR_ON_RESET_EN.
- When defined:
  - After rst deasserts, a CLEAR state writes 0x00 to indices 0..VRAM_DEPTH-1, one per clk (2048 clks).
  - busy = 1 throughout CLEAR.
  - No CPU acks; vid_valid stays 0; the slot counter is held at 0.
  - On the cycle after the last write: busy = 0 and normal slot operation starts at slot 0.
  - rst during CLEAR restarts it from index 0.
- When undefined: busy is tied 0, and slot operation starts in the first clk after reset.

Test Plan:
- Reset release, tile_RAM_addr = palette_RAM_addr = 0x0000 held -> every 4th clk vid_valid pulses with tile_ROM_addr = 0x00 and palette_ROM_addr = 0x00; cpu_ack stays 0.
- CPU write 0x4025 <= 0x5A and 0x4425 <= 0x3F, then renderer drives 0x4025/0x4425 -> the next vid_valid shows tile_ROM_addr = 0x5A and palette_ROM_addr = 0x3F; data appears 3 clks after the slot 0 sample.
- CPU write 0x4100 <= 0xA7, then CPU read 0x4100 -> cpu_rdata = 0xA7 with cpu_ack; each ack is 1 clk wide, lands in slot 3, and arrives ≤ 4 clks after req.
- CPU write 0x5000 <= 0x11, then read 0x5000 -> both acked; read data 0xFF; a read of 0x4000 is unchanged.
- Assert rst for 1 clk while cpu_req is pending in slot 1 -> no ack, outputs return to 0; req still high is acked in the first slot 3 after release.
- With VRAM_CLEAR_ON_RESET_EN: preload 0x4010 = 0x77, pulse rst -> busy is high for exactly 2048 clks; a CPU read of 0x4010 afterwards returns 0x00.
